// File: rtl/ysyx_icache.sv
// rtl/ysyx_icache.sv - direct-mapped instruction cache with line refill FSM
// Define YSYX_ICACHE_BURST_EN for one burst read per line; default is one single-beat read per word.
module ysyx_icache #(
    parameter int DATA_W   = 32,
    parameter int SET_LEN  = 2,
    parameter int LINE_LEN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ifu_pc_i,
    input  logic              ifu_req_i,
    input  logic              fence_i,
    output logic [31:0]       inst_o,
    output logic              hit_o,
    output logic [DATA_W-1:0] ifu_araddr_o,
    output logic              ifu_arvalid_o,
    output logic [7:0]        ifu_arlen_o,
    output logic              ifu_required_o,
    input  logic [DATA_W-1:0] ifu_rdata,
    input  logic              ifu_rvalid,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int SETS       = 2 ** SET_LEN;
    localparam int LINE_WORDS = 2 ** LINE_LEN;
    localparam int IDX_LSB    = LINE_LEN + 2;
    localparam int TAG_LSB    = SET_LEN + LINE_LEN + 2;
    localparam int TAG_W      = DATA_W - TAG_LSB;
    localparam int HI_W       = DATA_W - IDX_LSB;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SETS-1:0]        valid;
    logic [TAG_W-1:0]       tags     [SETS];
    logic [DATA_W-1:0]      data_mem [SETS][LINE_WORDS];
    logic [HI_W-1:0]        base_hi;
    logic [LINE_LEN-1:0]    count;
    logic                   fence_pend;
    logic                   start;
    logic                   beat;
    logic                   unused_pc_bits;

    logic [TAG_W-1:0]       pc_tag;
    logic [SET_LEN-1:0]     pc_idx;
    logic [LINE_LEN-1:0]    pc_off;
    logic [SET_LEN-1:0]     lat_idx;
    logic [TAG_W-1:0]       lat_tag;
    logic [DATA_W-1:0]      rd_word;
    logic                   drop_line;

    assign pc_tag         = ifu_pc_i[DATA_W-1:TAG_LSB];
    assign pc_idx         = ifu_pc_i[TAG_LSB-1:IDX_LSB];
    assign pc_off         = ifu_pc_i[IDX_LSB-1:2];
    assign unused_pc_bits = ^ifu_pc_i[1:0];

    // base_hi holds {tag, idx} of the line being refilled; word offset comes from count
    assign lat_idx = base_hi[SET_LEN-1:0];
    assign lat_tag = base_hi[HI_W-1:SET_LEN];

    assign hit_o          = (state == IDLE) && valid[pc_idx] && (tags[pc_idx] == pc_tag);
    assign rd_word        = data_mem[pc_idx][pc_off];
    assign inst_o         = rd_word[31:0];
    assign ifu_araddr_o   = {base_hi, count, 2'b00};
    assign ifu_required_o = (state != IDLE);
    assign drop_line      = fence_pend || fence_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ifu_arvalid_o = 1'b0;
        ifu_arlen_o   = 8'd0;
        start         = 1'b0;
        beat          = 1'b0;
        case (state)
            IDLE: begin
                if (ifu_req_i && !hit_o && !fence_i) begin
                    start     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                ifu_arvalid_o = 1'b1;
`ifdef YSYX_ICACHE_BURST_EN
                ifu_arlen_o = 8'(LINE_WORDS - 1);
                state_nxt   = WAIT;
`else
                if (ifu_rvalid) begin
                    beat = 1'b1;
                    if (&count) begin
                        state_nxt = DONE;
                    end
                end
`endif
            end
            WAIT: begin
`ifdef YSYX_ICACHE_BURST_EN
                if (ifu_rvalid) begin
                    beat = 1'b1;
                    if (&count) begin
                        state_nxt = DONE;
                    end
                end
`else
                state_nxt = IDLE;
`endif
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            fence_pend <= 1'b0;
            count      <= '0;
            hit_cnt_o  <= 32'd0;
            miss_cnt_o <= 32'd0;
        end else begin
            if (ifu_req_i && hit_o) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (start) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
                count      <= '0;
            end
            if (beat) begin
                count <= count + 1'b1;
            end
            if (state == IDLE && fence_i) begin
                valid <= '0;
            end
            if ((state == REQ || state == WAIT) && fence_i) begin
                fence_pend <= 1'b1;
            end
            // a fence seen anywhere during the refill discards everything, including this line
            if (state == DONE) begin
                fence_pend <= 1'b0;
                if (drop_line) begin
                    valid <= '0;
                end else begin
                    valid[lat_idx] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            base_hi <= ifu_pc_i[DATA_W-1:IDX_LSB];
        end
        if (beat) begin
            data_mem[lat_idx][count] <= ifu_rdata;
        end
        if (state == DONE && !drop_line) begin
            tags[lat_idx] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_ysyx_icache.sv
// tb/tb_ysyx_icache.sv - randomized self-checking bench for ysyx_icache against a line-level cache model
module tb_ysyx_icache;

    logic        clk;
    logic        rst;
    logic [31:0] ifu_pc_i;
    logic        ifu_req_i;
    logic        fence_i;
    logic [31:0] inst_o;
    logic        hit_o;
    logic [31:0] ifu_araddr_o;
    logic        ifu_arvalid_o;
    logic [7:0]  ifu_arlen_o;
    logic        ifu_required_o;
    logic [31:0] ifu_rdata;
    logic        ifu_rvalid;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    int total = 0;
    int bad   = 0;

    bit          mvalid [4];
    logic [26:0] mtag   [4];
    int          mhits;
    int          mmiss;

    ysyx_icache dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_pc_i      (ifu_pc_i),
        .ifu_req_i     (ifu_req_i),
        .fence_i       (fence_i),
        .inst_o        (inst_o),
        .hit_o         (hit_o),
        .ifu_araddr_o  (ifu_araddr_o),
        .ifu_arvalid_o (ifu_arvalid_o),
        .ifu_arlen_o   (ifu_arlen_o),
        .ifu_required_o(ifu_required_o),
        .ifu_rdata     (ifu_rdata),
        .ifu_rvalid    (ifu_rvalid),
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0013;
        if (a == 32'h8000_0004) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return mvalid[pc[4:3]] && (mtag[pc[4:3]] == pc[31:5]);
    endfunction

    function automatic logic [31:0] model_inst(input logic [31:0] pc);
        return mem_word({pc[31:2], 2'b00});
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 4; s++) mvalid[s] = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        ifu_rvalid = 1'b0;
        fence_i    = 1'b0;
        ifu_rdata  = $urandom;
        ifu_pc_i   = $urandom;
        ifu_req_i  = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ifu_req_i  = 1'b0;
            fence_i    = 1'b0;
            ifu_rvalid = 1'($urandom_range(0, 1));
            ifu_rdata  = $urandom;
            #1;
        end
        @(negedge clk);
        ifu_rvalid = 1'b0;
        #1;
    endtask

    // mode 0: normal refill, 1: fence pulsed with the first beat, 2: reset after the first beat
    task automatic serve(input logic [31:0] pc, input int mode, output bit addr_ok, output bit tmo);
        logic [31:0] base;
        int waits;
        base    = {pc[31:3], 3'b000};
        addr_ok = 1'b1;
        tmo     = 1'b0;
`ifdef YSYX_ICACHE_BURST_EN
        waits = 0;
        step();
        while (!ifu_arvalid_o && waits < 20) begin step(); waits++; end
        if (!ifu_arvalid_o) begin tmo = 1'b1; return; end
        if (ifu_araddr_o !== base || ifu_arlen_o !== 8'd1) addr_ok = 1'b0;
        for (int w = 0; w < 2; w++) begin
            repeat (1 + $urandom_range(0, 2)) begin
                step();
                if (ifu_arvalid_o) addr_ok = 1'b0;
            end
            ifu_rvalid = 1'b1;
            ifu_rdata  = mem_word(base + 32'(4 * w));
            if (mode == 1 && w == 0) fence_i = 1'b1;
            if (mode == 2) break;
        end
`else
        for (int w = 0; w < 2; w++) begin
            waits = 0;
            step();
            while (!ifu_arvalid_o && waits < 20) begin step(); waits++; end
            if (!ifu_arvalid_o) begin tmo = 1'b1; return; end
            if (ifu_araddr_o !== base + 32'(4 * w) || ifu_arlen_o !== 8'd0) addr_ok = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                step();
                if (!ifu_arvalid_o || ifu_araddr_o !== base + 32'(4 * w)) addr_ok = 1'b0;
            end
            ifu_rvalid = 1'b1;
            ifu_rdata  = mem_word(base + 32'(4 * w));
            if (mode == 1 && w == 0) fence_i = 1'b1;
            if (mode == 2) break;
        end
`endif
        @(negedge clk);
        fence_i   = 1'b0;
        ifu_pc_i  = pc;
        ifu_req_i = 1'b0;
        if (mode == 2) begin
            ifu_rvalid = 1'b0;
            rst        = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            ifu_rvalid = 1'b1;
            ifu_rdata  = $urandom;
        end
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input int mode,
                         output bit hit_seen, output logic [31:0] inst_seen,
                         output bit addr_ok, output bit tmo, output bit done_hit,
                         output bit post_hit, output logic [31:0] post_inst);
        bit exp;
        exp = model_hit(pc);
        @(negedge clk);
        ifu_rvalid = 1'b0;
        fence_i    = 1'b0;
        ifu_pc_i   = pc;
        ifu_req_i  = 1'b1;
        #1;
        hit_seen  = hit_o;
        inst_seen = inst_o;
        addr_ok   = 1'b1;
        tmo       = 1'b0;
        done_hit  = 1'b0;
        post_hit  = hit_seen;
        post_inst = inst_seen;
        if (exp) mhits++; else mmiss++;
        if (!hit_seen) begin
            serve(pc, mode, addr_ok, tmo);
            if (mode != 2 && !tmo) begin
                done_hit = hit_o;
                @(negedge clk);
                ifu_rvalid = 1'b0;
                ifu_pc_i   = pc;
                #1;
                post_hit  = hit_o;
                post_inst = inst_o;
            end
        end
        if (!exp) begin
            if (mode == 0) begin
                mvalid[pc[4:3]] = 1'b1;
                mtag[pc[4:3]]   = pc[31:5];
            end else begin
                model_clear();
                if (mode == 2) begin mhits = 0; mmiss = 0; end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ifu_req_i = 1'b0; fence_i = 1'b0; ifu_rvalid = 1'b0;
        ifu_pc_i = 32'h8000_0000; ifu_rdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        model_clear(); mhits = 0; mmiss = 0;
        total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL reset_hit: got %b exp 0", hit_o); end
        total++; if (ifu_arvalid_o !== 1'b0) begin bad++; $display("FAIL reset_arvalid: got %b exp 0", ifu_arvalid_o); end
        total++; if (ifu_required_o !== 1'b0) begin bad++; $display("FAIL reset_required: got %b exp 0", ifu_required_o); end
        total++; if (ifu_arlen_o !== 8'd0) begin bad++; $display("FAIL reset_arlen: got %0d exp 0", ifu_arlen_o); end
        total++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_counters: got %0d/%0d exp 0/0", hit_cnt_o, miss_cnt_o); end
    endtask

    task automatic test_cold_miss();
        bit h, ok, to, dh, ph; logic [31:0] ins, pins;
        fetch(32'h8000_0004, 0, h, ins, ok, to, dh, ph, pins);
        total++; if (h !== 1'b0) begin bad++; $display("FAIL cold_miss: hit got %b exp 0", h); end
        total++; if (to !== 1'b0 || ok !== 1'b1) begin bad++; $display("FAIL cold_bus: timeout %b addr_ok %b exp 0/1", to, ok); end
        total++; if (dh !== 1'b0) begin bad++; $display("FAIL cold_done_hit: got %b exp 0", dh); end
        total++; if (ph !== 1'b1 || pins !== 32'h0010_0093) begin bad++; $display("FAIL cold_post: hit %b inst %h exp 1 00100093", ph, pins); end
        total++; if (miss_cnt_o !== 32'd1) begin bad++; $display("FAIL cold_miss_cnt: got %0d exp 1", miss_cnt_o); end
        fetch(32'h8000_0000, 0, h, ins, ok, to, dh, ph, pins);
        total++; if (h !== 1'b1 || ins !== 32'h0000_0013) begin bad++; $display("FAIL cold_word0: hit %b inst %h exp 1 00000013", h, ins); end
    endtask

    task automatic test_conflict();
        bit h, ok, to, dh, ph; logic [31:0] ins, pins;
        fetch(32'h8000_0020, 0, h, ins, ok, to, dh, ph, pins);
        total++; if (h !== 1'b0 || ok !== 1'b1 || to !== 1'b0) begin bad++; $display("FAIL conflict_miss: hit %b ok %b to %b exp 0 1 0", h, ok, to); end
        total++; if (ph !== 1'b1 || pins !== mem_word(32'h8000_0020)) begin bad++; $display("FAIL conflict_fill: hit %b inst %h exp 1 %h", ph, pins, mem_word(32'h8000_0020)); end
        fetch(32'h8000_0000, 0, h, ins, ok, to, dh, ph, pins);
        total++; if (h !== 1'b0) begin bad++; $display("FAIL conflict_evict: hit got %b exp 0", h); end
        total++; if (miss_cnt_o !== 32'd3) begin bad++; $display("FAIL conflict_miss_cnt: got %0d exp 3", miss_cnt_o); end
    endtask

    task automatic test_fence_idle();
        bit h, ok, to, dh, ph; logic [31:0] ins, pins;
        fetch(32'h8000_0008, 0, h, ins, ok, to, dh, ph, pins);
        @(negedge clk);
        fence_i = 1'b1; ifu_req_i = 1'b1; ifu_pc_i = 32'h8000_0108;
        @(negedge clk);
        fence_i = 1'b0; ifu_req_i = 1'b0; ifu_pc_i = 32'h8000_0008;
        #1;
        model_clear();
        total++; if (ifu_required_o !== 1'b0) begin bad++; $display("FAIL fence_idle_nostart: required %b exp 0", ifu_required_o); end
        total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL fence_idle_inval: hit %b exp 0", hit_o); end
        fetch(32'h8000_0008, 0, h, ins, ok, to, dh, ph, pins);
        total++; if (h !== 1'b0 || ph !== 1'b1 || pins !== mem_word(32'h8000_0008)) begin bad++; $display("FAIL fence_idle_refill: hit %b post %b inst %h", h, ph, pins); end
    endtask

    task automatic test_fence_refill();
        bit h, ok, to, dh, ph; logic [31:0] ins, pins;
        fetch(32'h8000_0010, 1, h, ins, ok, to, dh, ph, pins);
        total++; if (h !== 1'b0 || ok !== 1'b1 || to !== 1'b0) begin bad++; $display("FAIL fence_refill_bus: hit %b ok %b to %b exp 0 1 0", h, ok, to); end
        total++; if (ph !== 1'b0) begin bad++; $display("FAIL fence_refill_inval: post hit %b exp 0", ph); end
        fetch(32'h8000_0010, 0, h, ins, ok, to, dh, ph, pins);
        total++; if (h !== 1'b0) begin bad++; $display("FAIL fence_refill_remiss: hit %b exp 0", h); end
        total++; if (ph !== 1'b1 || pins !== mem_word(32'h8000_0010)) begin bad++; $display("FAIL fence_refill_fill: hit %b inst %h", ph, pins); end
    endtask

    task automatic test_reset_mid();
        bit h, ok, to, dh, ph, exp; logic [31:0] ins, pins;
        logic [31:0] pcs [3];
        pcs[0] = 32'h8000_0008; pcs[1] = 32'h8000_0010; pcs[2] = 32'h8000_0018;
        fetch(pcs[2], 0, h, ins, ok, to, dh, ph, pins);
        fetch(32'h8000_0030, 2, h, ins, ok, to, dh, ph, pins);
        total++; if (ifu_required_o !== 1'b0 || ifu_arvalid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_idle: required %b arvalid %b exp 0 0", ifu_required_o, ifu_arvalid_o); end
        total++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin bad++; $display("FAIL rst_mid_counters: got %0d/%0d exp 0/0", hit_cnt_o, miss_cnt_o); end
        for (int i = 0; i < 3; i++) begin
            exp = model_hit(pcs[i]);
            fetch(pcs[i], 0, h, ins, ok, to, dh, ph, pins);
            total++; if (h !== exp) begin bad++; $display("FAIL rst_mid_miss%0d: hit %b exp %b", i, h, exp); end
        end
        total++; if (miss_cnt_o !== 32'(mmiss)) begin bad++; $display("FAIL rst_mid_miss_cnt: got %0d exp %0d", miss_cnt_o, mmiss); end
    endtask

    task automatic test_random();
        bit h, ok, to, dh, ph, exp; logic [31:0] ins, pins, pc;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk);
                fence_i = 1'b1; ifu_req_i = 1'b0;
                model_clear();
            end
            pc  = 32'h8000_0000 + 32'(4 * $urandom_range(0, 31));
            exp = model_hit(pc);
            fetch(pc, 0, h, ins, ok, to, dh, ph, pins);
            total++; if (h !== exp) begin bad++; $display("FAIL rand_hit pc=%h: got %b exp %b", pc, h, exp); end
            if (exp && h) begin
                total++; if (ins !== model_inst(pc)) begin bad++; $display("FAIL rand_inst pc=%h: got %h exp %h", pc, ins, model_inst(pc)); end
            end
            if (!h) begin
                total++; if (ok !== 1'b1 || to !== 1'b0 || ph !== 1'b1 || pins !== model_inst(pc)) begin bad++; $display("FAIL rand_refill pc=%h: ok %b to %b hit %b inst %h exp %h", pc, ok, to, ph, pins, model_inst(pc)); end
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        total++; if (hit_cnt_o !== 32'(mhits) || miss_cnt_o !== 32'(mmiss)) begin bad++; $display("FAIL rand_counters: got %0d/%0d exp %0d/%0d", hit_cnt_o, miss_cnt_o, mhits, mmiss); end
    endtask

    task automatic test_back_to_back();
        bit h, ok, to, dh, ph; logic [31:0] ins, pins, pc;
        int start_miss, errs;
        fetch(32'h8000_0040, 0, h, ins, ok, to, dh, ph, pins);
        idle(1);
        start_miss = mmiss;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            pc = 32'h8000_0040 + 32'(4 * (i % 2));
            ifu_pc_i = pc; ifu_req_i = 1'b1;
            #1;
            if (model_hit(pc)) mhits++;
            total++; if (hit_o !== 1'b1 || inst_o !== model_inst(pc)) begin bad++; errs++; if (errs < 5) $display("FAIL b2b_hit%0d: hit %b inst %h exp 1 %h", i, hit_o, inst_o, model_inst(pc)); end
        end
        @(negedge clk);
        ifu_req_i = 1'b0;
        #1;
        total++; if (hit_cnt_o !== 32'(mhits)) begin bad++; $display("FAIL b2b_hit_cnt: got %0d exp %0d", hit_cnt_o, mhits); end
        total++; if (miss_cnt_o !== 32'(start_miss)) begin bad++; $display("FAIL b2b_miss_cnt: got %0d exp %0d", miss_cnt_o, start_miss); end
    endtask

    initial begin
        rst = 1'b1; ifu_req_i = 1'b0; fence_i = 1'b0; ifu_rvalid = 1'b0;
        ifu_pc_i = 32'd0; ifu_rdata = 32'd0;
        mhits = 0; mmiss = 0;
        test_reset();
        test_cold_miss();
        test_conflict();
        test_fence_idle();
        test_fence_refill();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
